// File: rtl/muntjac_fetch_queue.sv
// muntjac_fetch_queue: circular fetch queue with optional empty-queue bypass and flush
module muntjac_fetch_queue #(
  parameter int unsigned DataWidth   = 128,
  parameter int unsigned Depth       = 4,
  parameter bit          FallThrough = 1'b1
) (
  input  logic                         clk_i,
  input  logic                         rst_ni,
  input  logic                         flush_i,
  input  logic                         in_valid_i,
  output logic                         in_ready_o,
  input  logic [DataWidth-1:0]         in_data_i,
  output logic                         out_valid_o,
  input  logic                         out_ready_i,
  output logic [DataWidth-1:0]         out_data_o,
  output logic [$clog2(Depth+1)-1:0]   count_o
);
  localparam int unsigned PtrW = Depth > 1 ? $clog2(Depth) : 1;
  localparam int unsigned CntW = $clog2(Depth + 1);
  logic [DataWidth-1:0] mem [Depth];
  logic [PtrW-1:0] wptr, rptr;
  logic [CntW-1:0] count;
  logic empty, push, pop, wr, rd;
  function automatic logic [PtrW-1:0] inc(input logic [PtrW-1:0] p);
    return p == PtrW'(Depth - 1) ? '0 : p + 1'b1;
  endfunction
  assign empty       = count == '0;
  assign in_ready_o  = !flush_i && (count < CntW'(Depth));
  assign out_valid_o = !flush_i && (!empty || (FallThrough && in_valid_i));
  assign out_data_o  = empty ? in_data_i : mem[rptr];
  assign push        = in_valid_i && in_ready_o;
  assign pop         = out_valid_o && out_ready_i;
  assign wr          = push && !(empty && pop);
  assign rd          = pop && !empty;
  assign count_o     = count;
  // pointer and occupancy bookkeeping; flush and reset both empty the queue
  always_ff @(posedge clk_i or negedge rst_ni)
    if (!rst_ni) begin
      wptr  <= '0;
      rptr  <= '0;
      count <= '0;
    end else if (flush_i) begin
      wptr  <= '0;
      rptr  <= '0;
      count <= '0;
    end else begin
      if (wr) wptr <= inc(wptr);
      if (rd) rptr <= inc(rptr);
      count <= count + CntW'(wr) - CntW'(rd);
    end
  // payload storage, deliberately not reset
  always_ff @(posedge clk_i)
    if (wr) mem[wptr] <= in_data_i;
endmodule

// File: tb/tb_muntjac_fetch_queue.sv
// tb_muntjac_fetch_queue: vector table plus queue-model scoreboard over three queue configurations
module tb_muntjac_fetch_queue;
  logic clk_i = 1'b0, rst_ni = 1'b0, flush_i = 1'b0, in_valid_i = 1'b0, out_ready_i = 1'b0;
  logic [7:0] in_data_i = '0;
  logic [2:0] ir, ov;
  logic [7:0] od0, od1, od2;
  logic [2:0] c0, c1;
  logic [1:0] c2;
  int n_vec = 0, n_bad = 0;
  bit [7:0] mq [3][$];
  typedef struct packed {
    logic iv; logic [7:0] d; logic ordy; logic fl;
    logic e_ir; logic e_ov; logic [7:0] e_od; logic [2:0] e_cnt;
  } vec_t;
  vec_t tab [22];
  vec_t cur;
  bit use_tab = 0;

  always #5 clk_i = ~clk_i;

  muntjac_fetch_queue #(.DataWidth(8), .Depth(4), .FallThrough(1'b0)) u0 (
    .clk_i(clk_i), .rst_ni(rst_ni), .flush_i(flush_i), .in_valid_i(in_valid_i),
    .in_ready_o(ir[0]), .in_data_i(in_data_i), .out_valid_o(ov[0]),
    .out_ready_i(out_ready_i), .out_data_o(od0), .count_o(c0));
  muntjac_fetch_queue #(.DataWidth(8), .Depth(4), .FallThrough(1'b1)) u1 (
    .clk_i(clk_i), .rst_ni(rst_ni), .flush_i(flush_i), .in_valid_i(in_valid_i),
    .in_ready_o(ir[1]), .in_data_i(in_data_i), .out_valid_o(ov[1]),
    .out_ready_i(out_ready_i), .out_data_o(od1), .count_o(c1));
  muntjac_fetch_queue #(.DataWidth(8), .Depth(3), .FallThrough(1'b0)) u2 (
    .clk_i(clk_i), .rst_ni(rst_ni), .flush_i(flush_i), .in_valid_i(in_valid_i),
    .in_ready_o(ir[2]), .in_data_i(in_data_i), .out_valid_o(ov[2]),
    .out_ready_i(out_ready_i), .out_data_o(od2), .count_o(c2));

  task automatic cmp(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic check_dut(input int k, input int d, input bit ft, input logic r, input logic v,
                           input logic [7:0] o, input int c);
    int sz;
    bit e_ir, e_ov;
    sz   = mq[k].size();
    e_ir = !flush_i && sz < d;
    e_ov = !flush_i && (sz != 0 || (ft && in_valid_i));
    cmp($sformatf("u%0d in_ready", k), 32'(r), 32'(e_ir));
    cmp($sformatf("u%0d out_valid", k), 32'(v), 32'(e_ov));
    cmp($sformatf("u%0d count", k), 32'(c), 32'(sz));
    if (e_ov) cmp($sformatf("u%0d out_data", k), 32'(o), 32'(sz != 0 ? mq[k][0] : in_data_i));
    if (flush_i) mq[k].delete();
    else begin
      if (in_valid_i && e_ir) mq[k].push_back(in_data_i);
      if (e_ov && out_ready_i) void'(mq[k].pop_front());
    end
  endtask

  task automatic chk();
    if (use_tab) begin
      cmp("tab in_ready", 32'(ir[0]), 32'(cur.e_ir));
      cmp("tab out_valid", 32'(ov[0]), 32'(cur.e_ov));
      cmp("tab count", 32'(c0), 32'(cur.e_cnt));
      if (cur.e_ov) cmp("tab out_data", 32'(od0), 32'(cur.e_od));
    end
    check_dut(0, 4, 1'b0, ir[0], ov[0], od0, int'(c0));
    check_dut(1, 4, 1'b1, ir[1], ov[1], od1, int'(c1));
    check_dut(2, 3, 1'b0, ir[2], ov[2], od2, int'(c2));
  endtask

  task automatic tick();
    @(negedge clk_i);
    chk();
    @(posedge clk_i);
    #1;
  endtask

  task automatic drive(input logic iv, input logic [7:0] d, input logic ordy, input logic fl);
    in_valid_i = iv; in_data_i = d; out_ready_i = ordy; flush_i = fl;
  endtask

  initial begin
    // iv, data, ordy, flush, exp in_ready, exp out_valid, exp out_data, exp count (u0: Depth 4, no bypass)
    tab[0]  = '{1'b1, 8'hA1, 1'b0, 1'b0, 1'b1, 1'b0, 8'h00, 3'd0};
    tab[1]  = '{1'b1, 8'hB2, 1'b0, 1'b0, 1'b1, 1'b1, 8'hA1, 3'd1};
    tab[2]  = '{1'b1, 8'hC3, 1'b0, 1'b0, 1'b1, 1'b1, 8'hA1, 3'd2};
    tab[3]  = '{1'b1, 8'hD4, 1'b0, 1'b0, 1'b1, 1'b1, 8'hA1, 3'd3};
    tab[4]  = '{1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b1, 8'hA1, 3'd4};
    tab[5]  = '{1'b0, 8'h00, 1'b1, 1'b0, 1'b0, 1'b1, 8'hA1, 3'd4};
    tab[6]  = '{1'b0, 8'h00, 1'b1, 1'b0, 1'b1, 1'b1, 8'hB2, 3'd3};
    tab[7]  = '{1'b0, 8'h00, 1'b1, 1'b0, 1'b1, 1'b1, 8'hC3, 3'd2};
    tab[8]  = '{1'b0, 8'h00, 1'b1, 1'b0, 1'b1, 1'b1, 8'hD4, 3'd1};
    tab[9]  = '{1'b0, 8'h00, 1'b0, 1'b0, 1'b1, 1'b0, 8'h00, 3'd0};
    tab[10] = '{1'b1, 8'h11, 1'b0, 1'b0, 1'b1, 1'b0, 8'h00, 3'd0};
    tab[11] = '{1'b1, 8'h12, 1'b0, 1'b0, 1'b1, 1'b1, 8'h11, 3'd1};
    tab[12] = '{1'b1, 8'h13, 1'b0, 1'b0, 1'b1, 1'b1, 8'h11, 3'd2};
    tab[13] = '{1'b1, 8'h14, 1'b0, 1'b0, 1'b1, 1'b1, 8'h11, 3'd3};
    tab[14] = '{1'b1, 8'h15, 1'b1, 1'b0, 1'b0, 1'b1, 8'h11, 3'd4};
    tab[15] = '{1'b1, 8'h15, 1'b0, 1'b0, 1'b1, 1'b1, 8'h12, 3'd3};
    tab[16] = '{1'b0, 8'h00, 1'b1, 1'b0, 1'b0, 1'b1, 8'h12, 3'd4};
    tab[17] = '{1'b0, 8'h00, 1'b0, 1'b0, 1'b1, 1'b1, 8'h13, 3'd3};
    tab[18] = '{1'b1, 8'h16, 1'b0, 1'b1, 1'b0, 1'b0, 8'h00, 3'd3};
    tab[19] = '{1'b1, 8'h17, 1'b0, 1'b0, 1'b1, 1'b0, 8'h00, 3'd0};
    tab[20] = '{1'b0, 8'h00, 1'b1, 1'b0, 1'b1, 1'b1, 8'h17, 3'd1};
    tab[21] = '{1'b0, 8'h00, 1'b0, 1'b0, 1'b1, 1'b0, 8'h00, 3'd0};
    #1;
    cmp("reset count", 32'(c0), 32'd0);
    cmp("reset in_ready", 32'(ir), 32'h7);
    cmp("reset out_valid", 32'(ov), 32'h0);
    #11;
    rst_ni = 1'b1;
    @(posedge clk_i);
    #1;
    use_tab = 1;
    for (int i = 0; i < 22; i++) begin
      cur = tab[i];
      drive(cur.iv, cur.d, cur.ordy, cur.fl);
      tick();
    end
    use_tab = 0;
    for (int i = 0; i < 12; i++) begin
      drive(1'b1, 8'(8'h20 + i), i > 0, 1'b0);
      tick();
    end
    for (int i = 0; i < 40; i++) begin
      drive(1'($urandom_range(0, 1)), 8'($urandom), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 15) == 0));
      tick();
    end
    drive(1'b0, 8'h00, 1'b0, 1'b1);
    tick();
    drive(1'b1, 8'h5A, 1'b1, 1'b0);
    @(negedge clk_i);
    cmp("bypass out_valid", 32'(ov[1]), 32'd1);
    cmp("bypass out_data", 32'(od1), 32'h5A);
    cmp("bypass count", 32'(c1), 32'd0);
    cmp("no bypass out_valid", 32'(ov[0]), 32'd0);
    chk();
    @(posedge clk_i);
    #1;
    cmp("bypass count after", 32'(c1), 32'd0);
    drive(1'b0, 8'h00, 1'b0, 1'b1);
    tick();
    drive(1'b1, 8'h40, 1'b0, 1'b0);
    tick();
    drive(1'b1, 8'h41, 1'b0, 1'b0);
    tick();
    drive(1'b0, 8'h00, 1'b0, 1'b0);
    #2;
    cmp("pre-reset count", 32'(c0), 32'd2);
    rst_ni = 1'b0;
    #1;
    cmp("async reset count u0", 32'(c0), 32'd0);
    cmp("async reset count u1", 32'(c1), 32'd0);
    cmp("async reset out_valid", 32'(ov), 32'h0);
    for (int k = 0; k < 3; k++) mq[k].delete();
    @(posedge clk_i);
    #2;
    rst_ni = 1'b1;
    @(negedge clk_i);
    cmp("post-reset in_ready", 32'(ir), 32'h7);
    @(posedge clk_i);
    #1;
    for (int i = 0; i < 6; i++) begin
      drive(1'b1, 8'(8'h60 + i), i[0], 1'b0);
      tick();
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end
endmodule
